// File: rtl/ahb3lite_sram_slave.sv
// AHB3-Lite slave over a word-organised on-chip memory with configurable wait
// states, byte/halfword/word writes and two-cycle ERROR responses.
module ahb3lite_sram_slave #(
  parameter int HADDR_SIZE  = 32,
  parameter int HDATA_SIZE  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [HADDR_SIZE-1:0] HADDR,
  input  logic [HDATA_SIZE-1:0] HWDATA,
  output logic [HDATA_SIZE-1:0] HRDATA,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [1:0]            HTRANS,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP
);

  localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WAIT = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_ERR1 = 3'd3;
  localparam logic [2:0] ST_ERR2 = 3'd4;

  localparam logic [HADDR_SIZE-3:0] WORD_LIMIT = (HADDR_SIZE-2)'(MEM_DEPTH);
  localparam logic [3:0]            WAIT_LOAD  = 4'(WAIT_STATES);

  function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] offs);
    case (size)
      3'd0:    lane_mask = 4'b0001 << offs;
      3'd1:    lane_mask = offs[1] ? 4'b1100 : 4'b0011;
      3'd2:    lane_mask = 4'b1111;
      default: lane_mask = 4'b0000;
    endcase
  endfunction

  function automatic logic xfer_error(input logic [HADDR_SIZE-1:0] addr, input logic [2:0] size);
    xfer_error = (addr[HADDR_SIZE-1:2] >= WORD_LIMIT) ||
                 (size > 3'd2) ||
                 ((size == 3'd1) && addr[0]) ||
                 ((size == 3'd2) && (addr[1:0] != 2'b00));
  endfunction

  logic [HDATA_SIZE-1:0] mem [MEM_DEPTH];

  logic [2:0]    state_r;
  logic [3:0]    cnt_r;
  logic [AW-1:0] addr_r;
  logic          write_r;
  logic [3:0]    mask_r;
  logic          ready_r;
  logic          resp_r;

  logic          accept_s;
  logic          err_s;
  logic [2:0]    state_nx_s;
  logic [3:0]    cnt_nx_s;
  logic          unused_s;

  assign unused_s = ^{HBURST, HPROT, HTRANS[0]};

  // Next-state decode; only a ready slave (IDLE, DATA, ERR2) can take a new address phase.
  always_comb begin
    accept_s   = HSEL & HREADY & HTRANS[1] & ready_r;
    err_s      = xfer_error(HADDR, HSIZE);
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    case (state_r)
      ST_WAIT: begin
        if (cnt_r <= 4'd1) begin
          state_nx_s = ST_DATA;
          cnt_nx_s   = 4'd0;
        end else begin
          state_nx_s = ST_WAIT;
          cnt_nx_s   = cnt_r - 4'd1;
        end
      end
      ST_ERR1: state_nx_s = ST_ERR2;
      default: begin
        if (accept_s && err_s) begin
          state_nx_s = ST_ERR1;
        end else if (accept_s && (WAIT_STATES > 0)) begin
          state_nx_s = ST_WAIT;
          cnt_nx_s   = WAIT_LOAD;
        end else if (accept_s) begin
          state_nx_s = ST_DATA;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
    endcase
  end

  // Control registers, response flops and captured address phase.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
      addr_r  <= '0;
      write_r <= 1'b0;
      mask_r  <= 4'b0000;
      ready_r <= 1'b1;
      resp_r  <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
      ready_r <= !((state_nx_s == ST_WAIT) || (state_nx_s == ST_ERR1));
      resp_r  <= (state_nx_s == ST_ERR1) || (state_nx_s == ST_ERR2);
      if (accept_s) begin
        addr_r  <= HADDR[AW+1:2];
        write_r <= HWRITE & ~err_s;
        mask_r  <= lane_mask(HSIZE, HADDR[1:0]);
      end
    end
  end

  // Memory has no reset; a write held in reset is dropped.
  always_ff @(posedge HCLK) begin
    if (HRESETn && (state_r == ST_DATA) && write_r) begin
      for (int i = 0; i < 4; i++) begin
        if (mask_r[i]) begin
          mem[addr_r][8*i +: 8] <= HWDATA[8*i +: 8];
        end
      end
    end
  end

  assign HRDATA    = ((state_r == ST_DATA) && !write_r) ? mem[addr_r] : '0;
  assign HREADYOUT = ready_r;
  assign HRESP     = resp_r;

endmodule

// File: tb/tb_ahb3lite_sram_slave.sv
// Directed bench: three slaves (0, 2 and 3 wait states) on one shared bus,
// one selected at a time, each HREADY looped back from its own HREADYOUT.
module tb_ahb3lite_sram_slave;

  logic        clk;
  logic        hresetn;
  logic [2:0]  sel;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic [1:0]  htrans;

  logic        rdy0, rdy1, rdy2;
  logic        resp0, resp1, resp2;
  logic [31:0] rd0, rd1, rd2;
  logic [2:0]  rdy_v, resp_v;

  int n_cmp = 0;
  int n_bad = 0;

  assign rdy_v  = {rdy2, rdy1, rdy0};
  assign resp_v = {resp2, resp1, resp0};

  ahb3lite_sram_slave #(.WAIT_STATES(0)) u_w0 (
    .HCLK(clk), .HRESETn(hresetn), .HSEL(sel[0]), .HADDR(haddr), .HWDATA(hwdata),
    .HRDATA(rd0), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot),
    .HTRANS(htrans), .HREADY(rdy0), .HREADYOUT(rdy0), .HRESP(resp0)
  );

  ahb3lite_sram_slave #(.WAIT_STATES(2)) u_w2 (
    .HCLK(clk), .HRESETn(hresetn), .HSEL(sel[1]), .HADDR(haddr), .HWDATA(hwdata),
    .HRDATA(rd1), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot),
    .HTRANS(htrans), .HREADY(rdy1), .HREADYOUT(rdy1), .HRESP(resp1)
  );

  ahb3lite_sram_slave #(.WAIT_STATES(3)) u_w3 (
    .HCLK(clk), .HRESETn(hresetn), .HSEL(sel[2]), .HADDR(haddr), .HWDATA(hwdata),
    .HRDATA(rd2), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot),
    .HTRANS(htrans), .HREADY(rdy2), .HREADYOUT(rdy2), .HRESP(resp2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  function automatic logic [31:0] rd_of(input int t);
    case (t)
      0:       rd_of = rd0;
      1:       rd_of = rd1;
      default: rd_of = rd2;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int t, input logic wr, input logic [2:0] sz, input logic [31:0] a);
    sel    = 3'b001 << t;
    hwrite = wr;
    hsize  = sz;
    haddr  = a;
    htrans = 2'b10;
  endtask

  task automatic bus_idle();
    sel    = 3'b000;
    hwrite = 1'b0;
    hsize  = 3'd0;
    haddr  = 32'h0000_0000;
    htrans = 2'b00;
  endtask

  task automatic chk_status(input string tag, input int t, input logic r, input logic e);
    chk({tag, "_ready"}, {31'd0, rdy_v[t[1:0]]}, {31'd0, r});
    chk({tag, "_resp"},  {31'd0, resp_v[t[1:0]]}, {31'd0, e});
  endtask

  // Non-pipelined OKAY transfer: counts wait cycles and checks read data.
  task automatic single(input int t, input logic wr, input logic [2:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, input int exp_waits, input logic [31:0] exp_rd,
                        input string tag);
    int waits;
    drive(t, wr, sz, a);
    step();
    bus_idle();
    hwdata = wd;
    waits  = 0;
    while (rdy_v[t[1:0]] !== 1'b1 && waits < 20) begin
      chk({tag, "_wait_resp"}, {31'd0, resp_v[t[1:0]]}, 32'd0);
      waits++;
      step();
    end
    chk({tag, "_waits"}, waits, exp_waits);
    chk({tag, "_resp"}, {31'd0, resp_v[t[1:0]]}, 32'd0);
    if (!wr) chk({tag, "_rdata"}, rd_of(t), exp_rd);
    step();
  endtask

  // Error transfer: 0/1 then 1/1, master drops to IDLE in ERR2.
  task automatic err_xfer(input int t, input logic wr, input logic [2:0] sz, input logic [31:0] a,
                          input string tag);
    drive(t, wr, sz, a);
    step();
    bus_idle();
    hwdata = 32'hFFFF_FFFF;
    chk_status({tag, "_err1"}, t, 1'b0, 1'b1);
    step();
    chk_status({tag, "_err2"}, t, 1'b1, 1'b1);
    step();
    chk_status({tag, "_after"}, t, 1'b1, 1'b0);
  endtask

  initial begin
    hresetn = 1'b0;
    hburst  = 3'd0;
    hprot   = 4'b0011;
    hwdata  = 32'h0000_0000;
    bus_idle();
    step();
    step();
    hresetn = 1'b1;
    for (int t = 0; t < 3; t++) begin
      chk_status("reset", t, 1'b1, 1'b0);
      chk("reset_rdata", rd_of(t), 32'h0000_0000);
    end

    // Word write then read, zero wait
    single(0, 1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF, 0, 32'h0, "t1_wr");
    single(0, 1'b0, 3'd2, 32'h10, 32'h0, 0, 32'hDEAD_BEEF, "t1_rd");
    chk("t1_idle_rdata", rd0, 32'h0000_0000);

    // Byte and halfword lane merging
    single(0, 1'b1, 3'd2, 32'h20, 32'h1122_3344, 0, 32'h0, "t2_wword");
    single(0, 1'b1, 3'd0, 32'h21, 32'h0000_AA00, 0, 32'h0, "t2_wbyte");
    single(0, 1'b1, 3'd1, 32'h22, 32'h5566_0000, 0, 32'h0, "t2_whalf");
    single(0, 1'b0, 3'd2, 32'h20, 32'h0, 0, 32'h5566_AA44, "t2_rd");

    // Two wait states: single transfers, then back-to-back writes
    single(1, 1'b1, 3'd2, 32'h10, 32'h0BAD_CAFE, 2, 32'h0, "t3_wr");
    single(1, 1'b0, 3'd2, 32'h10, 32'h0, 2, 32'h0BAD_CAFE, "t3_rd");
    drive(1, 1'b1, 3'd2, 32'h50);
    step();
    hwdata = 32'h1111_0000;
    drive(1, 1'b1, 3'd2, 32'h54);
    chk_status("t3_b2b_c1", 1, 1'b0, 1'b0);
    step();
    chk_status("t3_b2b_c2", 1, 1'b0, 1'b0);
    step();
    chk_status("t3_b2b_c3", 1, 1'b1, 1'b0);
    step();
    bus_idle();
    hwdata = 32'h2222_0000;
    chk_status("t3_b2b_c4", 1, 1'b0, 1'b0);
    step();
    chk_status("t3_b2b_c5", 1, 1'b0, 1'b0);
    step();
    chk_status("t3_b2b_c6", 1, 1'b1, 1'b0);
    step();
    single(1, 1'b0, 3'd2, 32'h50, 32'h0, 2, 32'h1111_0000, "t3_rd50");
    single(1, 1'b0, 3'd2, 32'h54, 32'h0, 2, 32'h2222_0000, "t3_rd54");

    // Error responses leave memory untouched
    single(0, 1'b1, 3'd2, 32'h00, 32'h1357_9BDF, 0, 32'h0, "t4_init");
    err_xfer(0, 1'b1, 3'd2, 32'h400, "t4_range");
    err_xfer(0, 1'b1, 3'd2, 32'h02, "t4_wmis");
    err_xfer(0, 1'b1, 3'd1, 32'h01, "t4_hmis");
    err_xfer(0, 1'b1, 3'd3, 32'h00, "t4_size");
    single(0, 1'b0, 3'd2, 32'h00, 32'h0, 0, 32'h1357_9BDF, "t4_rd");

    // Pipelined write then read of the same address
    drive(0, 1'b1, 3'd2, 32'h30);
    step();
    hwdata = 32'hCAFE_F00D;
    drive(0, 1'b0, 3'd2, 32'h30);
    chk_status("t5_wdata", 0, 1'b1, 1'b0);
    step();
    bus_idle();
    chk_status("t5_rdata_st", 0, 1'b1, 1'b0);
    chk("t5_rdata", rd0, 32'hCAFE_F00D);
    sel    = 3'b001;
    htrans = 2'b01;
    haddr  = 32'h30;
    step();
    chk_status("t5_after_rd", 0, 1'b1, 1'b0);
    htrans = 2'b00;
    step();
    chk_status("t5_busy", 0, 1'b1, 1'b0);
    chk("t5_busy_rdata", rd0, 32'h0000_0000);
    sel    = 3'b000;
    htrans = 2'b10;
    step();
    chk_status("t5_idle", 0, 1'b1, 1'b0);
    bus_idle();
    step();
    chk_status("t5_nosel", 0, 1'b1, 1'b0);
    chk("t5_nosel_rdata", rd0, 32'h0000_0000);

    // Reset in the middle of a three-wait write
    single(2, 1'b1, 3'd2, 32'h40, 32'h2468_1357, 3, 32'h0, "t6_init");
    drive(2, 1'b1, 3'd2, 32'h40);
    step();
    bus_idle();
    hwdata = 32'hFFFF_FFFF;
    chk_status("t6_w1", 2, 1'b0, 1'b0);
    step();
    chk_status("t6_w2", 2, 1'b0, 1'b0);
    hresetn = 1'b0;
    step();
    hresetn = 1'b1;
    chk_status("t6_reset", 2, 1'b1, 1'b0);
    chk("t6_reset_rdata", rd2, 32'h0000_0000);
    step();
    step();
    single(2, 1'b0, 3'd2, 32'h40, 32'h0, 3, 32'h2468_1357, "t6_rd");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
